// File: rtl/scc_pkg.sv
// Shared definitions for the wavetable engine: register select codes,
// control bit positions and the sequencer state encoding.
package scc_pkg;

    localparam logic [1:0] SEL_WAVE = 2'd0;
    localparam logic [1:0] SEL_FREQ = 2'd1;
    localparam logic [1:0] SEL_VOL  = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    localparam int CTRL_RST_ON_FREQ = 7;

    // Dividers below this value halt the channel.
    localparam int FREQ_MIN = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CH_SLOT,
        ST_OUTPUT
    } seq_state_t;

endpackage

// File: rtl/scc_wave_ram.sv
// Wave sample storage for all channels: one CPU read/write port plus an
// independent asynchronous read port for the sequencer.
module scc_wave_ram #(
    parameter int CH_COUNT = 5,
    parameter int WAVE_AW  = 5,
    localparam int AW      = $clog2(CH_COUNT) + WAVE_AW
) (
    input  logic          clk,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    input  logic [AW-1:0] seq_addr,
    output logic [7:0]    seq_rdata
);

    logic [7:0] r_mem [CH_COUNT * (2 ** WAVE_AW)];

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            r_mem[cpu_addr] <= cpu_wdata;
        end
    end

    // Reads are combinational, so a same-cycle write is seen only after the edge.
    assign cpu_rdata = r_mem[cpu_addr];
    assign seq_rdata = r_mem[seq_addr];

endmodule

// File: rtl/scc_wavetable_engine.sv
// N-channel wavetable sound engine: register file, wave RAM and a
// time-multiplexed sequencer that steps and mixes every channel once per round.
module scc_wavetable_engine
    import scc_pkg::*;
#(
    parameter int CH_COUNT = 5,
    parameter int WAVE_AW  = 5,
    parameter int FREQ_W   = 12,
    parameter int VOL_W    = 4,
    localparam int OUT_W   = 8 + VOL_W + $clog2(CH_COUNT)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    reg_wr,
    input  logic                    reg_rd,
    input  logic [1:0]              reg_sel,
    input  logic [2:0]              reg_ch,
    input  logic [WAVE_AW-1:0]      reg_idx,
    input  logic [7:0]              reg_wdata,
    output logic [7:0]              reg_rdata,
    output logic                    reg_rvalid,
    input  logic                    share_mode,
    output logic                    sample_tick,
    output logic signed [OUT_W-1:0] sound_out
);

    localparam int CHW    = $clog2(CH_COUNT);
    localparam int PROD_W = 8 + VOL_W;
    localparam int RAM_AW = CHW + WAVE_AW;

    function automatic logic signed [PROD_W-1:0] scale(input logic signed [7:0] s,
                                                       input logic [VOL_W-1:0] v);
        logic signed [PROD_W:0] p;
        p = s * $signed({1'b0, v});
        return p[PROD_W-1:0];
    endfunction

    seq_state_t              r_state, w_state_nxt;
    logic [CHW-1:0]          r_slot;
    logic signed [OUT_W-1:0] r_acc;
    logic [FREQ_W-1:0]       r_freq [CH_COUNT];
    logic [FREQ_W-1:0]       r_cnt  [CH_COUNT];
    logic [WAVE_AW-1:0]      r_ptr  [CH_COUNT];
    logic [VOL_W-1:0]        r_vol  [CH_COUNT];
    logic [7:0]              r_ctrl;

    logic                     w_ch_ok, w_cpu_shared, w_ram_we, w_in_slot, w_last_slot;
    logic [CHW-1:0]           w_cpu_ch, w_cpu_ram_ch, w_seq_ch;
    logic [7:0]               w_cpu_rdata, w_seq_rdata, w_rd_mux;
    logic signed [7:0]        w_seq_sample;
    logic signed [PROD_W-1:0] w_contrib;
    logic [CH_COUNT-1:0]      w_en, w_freq_wr, w_vol_wr;

    assign w_ch_ok      = int'(reg_ch) < CH_COUNT;
    assign w_cpu_ch     = reg_ch[CHW-1:0];
    // In share mode the last channel aliases onto the wave of the one before it.
    assign w_cpu_shared = share_mode && (int'(reg_ch) == CH_COUNT - 1);
    assign w_cpu_ram_ch = w_cpu_shared ? CHW'(CH_COUNT - 2) : w_cpu_ch;
    assign w_ram_we     = reg_wr && (reg_sel == SEL_WAVE) && w_ch_ok && !w_cpu_shared;

    assign w_in_slot    = (r_state == ST_CH_SLOT);
    assign w_last_slot  = (int'(r_slot) == CH_COUNT - 1);
    assign w_seq_ch     = (share_mode && w_last_slot) ? CHW'(CH_COUNT - 2) : r_slot;
    assign w_en         = r_ctrl[CH_COUNT-1:0];
    assign w_seq_sample = w_seq_rdata;
    assign w_contrib    = w_en[r_slot] ? scale(w_seq_sample, r_vol[r_slot]) : '0;

    scc_wave_ram #(
        .CH_COUNT (CH_COUNT),
        .WAVE_AW  (WAVE_AW)
    ) u_wave_ram (
        .clk       (clk),
        .cpu_we    (w_ram_we),
        .cpu_addr  (RAM_AW'({w_cpu_ram_ch, reg_idx})),
        .cpu_wdata (reg_wdata),
        .cpu_rdata (w_cpu_rdata),
        .seq_addr  (RAM_AW'({w_seq_ch, r_ptr[r_slot]})),
        .seq_rdata (w_seq_rdata)
    );

    always_comb begin
        for (int c = 0; c < CH_COUNT; c++) begin
            w_freq_wr[c] = reg_wr && (reg_sel == SEL_FREQ) && (int'(reg_ch) == c);
            w_vol_wr[c]  = reg_wr && (reg_sel == SEL_VOL)  && (int'(reg_ch) == c);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = ST_CH_SLOT;
            ST_CH_SLOT: if (w_last_slot) w_state_nxt = ST_OUTPUT;
            ST_OUTPUT:  w_state_nxt = ST_CH_SLOT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_slot      <= '0;
            r_acc       <= '0;
            sound_out   <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            if (r_state == ST_CH_SLOT) begin
                r_acc  <= r_acc + OUT_W'(w_contrib);
                r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
            end else if (r_state == ST_OUTPUT) begin
                sound_out   <= r_acc;
                sample_tick <= 1'b1;
                r_acc       <= '0;
            end
        end
    end

    // Per-channel registers; a reset-on-frequency write is ordered after the step so it wins.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < CH_COUNT; c++) begin
                r_freq[c] <= '0;
                r_cnt[c]  <= '0;
                r_ptr[c]  <= '0;
                r_vol[c]  <= '0;
            end
            r_ctrl <= '0;
        end else begin
            for (int c = 0; c < CH_COUNT; c++) begin
                if (w_in_slot && (int'(r_slot) == c) && (r_freq[c] >= FREQ_W'(FREQ_MIN))) begin
                    if (r_cnt[c] == '0) begin
                        r_cnt[c] <= r_freq[c];
                        r_ptr[c] <= r_ptr[c] + 1'b1;
                    end else begin
                        r_cnt[c] <= r_cnt[c] - 1'b1;
                    end
                end
                if (w_freq_wr[c]) begin
                    if (r_ctrl[CTRL_RST_ON_FREQ]) begin
                        r_cnt[c] <= '0;
                        r_ptr[c] <= '0;
                    end
                    if (reg_idx[0]) begin
                        r_freq[c][FREQ_W-1:8] <= reg_wdata[FREQ_W-9:0];
                    end else begin
                        r_freq[c][7:0] <= reg_wdata;
                    end
                end
                if (w_vol_wr[c]) begin
                    r_vol[c] <= reg_wdata[VOL_W-1:0];
                end
            end
            if (reg_wr && (reg_sel == SEL_CTRL) && w_ch_ok) begin
                r_ctrl <= reg_wdata;
            end
        end
    end

    always_comb begin
        w_rd_mux = 8'hFF;
        if (w_ch_ok) begin
            case (reg_sel)
                SEL_WAVE: w_rd_mux = w_cpu_rdata;
                SEL_FREQ: w_rd_mux = reg_idx[0] ? 8'(r_freq[w_cpu_ch][FREQ_W-1:8])
                                                : r_freq[w_cpu_ch][7:0];
                SEL_VOL:  w_rd_mux = 8'(r_vol[w_cpu_ch]);
                default:  w_rd_mux = r_ctrl;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd;
            if (reg_rd) begin
                reg_rdata <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_scc_wavetable_engine.sv
// Directed bench for scc_wavetable_engine: reset behaviour, pointer stepping,
// halted channels, full-scale mixing, share mode and reset-on-frequency writes.
module tb_scc_wavetable_engine;

    localparam logic [1:0] S_WAVE = 2'd0;
    localparam logic [1:0] S_FREQ = 2'd1;
    localparam logic [1:0] S_VOL  = 2'd2;
    localparam logic [1:0] S_CTRL = 2'd3;

    logic               clk = 1'b0;
    logic               n_reset = 1'b1;
    logic               reg_wr = 1'b0;
    logic               reg_rd = 1'b0;
    logic [1:0]         reg_sel = 2'd0;
    logic [2:0]         reg_ch = 3'd0;
    logic [4:0]         reg_idx = 5'd0;
    logic [7:0]         reg_wdata = 8'd0;
    logic [7:0]         reg_rdata;
    logic               reg_rvalid;
    logic               share_mode = 1'b0;
    logic               sample_tick;
    logic signed [14:0] sound_out;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    scc_wavetable_engine dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_sel     (reg_sel),
        .reg_ch      (reg_ch),
        .reg_idx     (reg_idx),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .share_mode  (share_mode),
        .sample_tick (sample_tick),
        .sound_out   (sound_out)
    );

    // Called at a negedge; the write is captured at the following posedge.
    task automatic wr(input logic [1:0] sel, input int ch, input int idx, input logic [7:0] d);
        reg_wr = 1'b1; reg_sel = sel; reg_ch = 3'(ch); reg_idx = 5'(idx); reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input int ch, input int idx,
                      output logic [7:0] d, output logic v);
        reg_rd = 1'b1; reg_sel = sel; reg_ch = 3'(ch); reg_idx = 5'(idx);
        @(negedge clk);
        reg_rd = 1'b0;
        d = reg_rdata;
        v = reg_rvalid;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_total++; n_bad++;
            $display("FAIL tick_timeout: no sample_tick within 40 clks");
        end
    endtask

    task automatic tick_latency(output int lat);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) lat = i;
        end
    endtask

    task automatic test_reset_init();
        int lat;
        #2 n_reset = 1'b0;
        @(negedge clk); @(negedge clk);
        n_total++; if (sound_out !== 15'sd0) begin n_bad++; $display("FAIL init_sound got=%0d want=0", sound_out); end
        n_total++; if (sample_tick !== 1'b0) begin n_bad++; $display("FAIL init_tick got=%b want=0", sample_tick); end
        n_total++; if (reg_rvalid !== 1'b0) begin n_bad++; $display("FAIL init_rvalid got=%b want=0", reg_rvalid); end
        n_total++; if (reg_rdata !== 8'h00) begin n_bad++; $display("FAIL init_rdata got=%h want=00", reg_rdata); end
        n_reset = 1'b1;
        tick_latency(lat);
        n_total++; if (lat != 7) begin n_bad++; $display("FAIL init_latency got=%0d want=7", lat); end
        n_total++; if (sound_out !== 15'sd0) begin n_bad++; $display("FAIL init_first_sample got=%0d want=0", sound_out); end
    endtask

    task automatic test_ramp();
        logic [7:0] d; logic v;
        logic signed [14:0] exp_s;
        for (int k = 0; k < 32; k++) wr(S_WAVE, 0, k, 8'(k * 4));
        wr(S_VOL, 0, 0, 8'd15);
        wr(S_CTRL, 0, 0, 8'h01);
        rd(S_VOL, 0, 0, d, v);
        n_total++; if (v !== 1'b1 || d !== 8'h0F) begin n_bad++; $display("FAIL ramp_vol_read got=%h/%b want=0f/1", d, v); end
        wait_tick();
        wr(S_FREQ, 0, 0, 8'd9);
        for (int n = 1; n <= 23; n++) begin
            wait_tick();
            exp_s = (n <= 2) ? 15'sd0 : 15'(60 * ((n - 3) / 10 + 1));
            n_total++; if (sound_out !== exp_s) begin n_bad++; $display("FAIL ramp_round%0d got=%0d want=%0d", n, sound_out, exp_s); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        wait_tick();
        @(posedge clk); @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        n_total++; if (sound_out !== 15'sd0) begin n_bad++; $display("FAIL mid_sound got=%0d want=0", sound_out); end
        n_total++; if (reg_rdata !== 8'h00) begin n_bad++; $display("FAIL mid_rdata got=%h want=00", reg_rdata); end
        n_total++; if (sample_tick !== 1'b0) begin n_bad++; $display("FAIL mid_tick got=%b want=0", sample_tick); end
        @(negedge clk); @(negedge clk);
        n_reset = 1'b1;
        tick_latency(lat);
        n_total++; if (lat != 7) begin n_bad++; $display("FAIL mid_latency got=%0d want=7", lat); end
        n_total++; if (sound_out !== 15'sd0) begin n_bad++; $display("FAIL mid_first_sample got=%0d want=0", sound_out); end
    endtask

    task automatic test_halt();
        wr(S_WAVE, 1, 0, 8'hFD);
        wr(S_WAVE, 1, 1, 8'h32);
        wr(S_VOL, 1, 0, 8'd15);
        wr(S_FREQ, 1, 0, 8'd8);
        wr(S_CTRL, 0, 0, 8'h02);
        wait_tick(); wait_tick();
        for (int n = 0; n < 12; n++) begin
            wait_tick();
            n_total++; if (sound_out !== -15'sd45) begin n_bad++; $display("FAIL halt_round%0d got=%0d want=-45", n, sound_out); end
        end
    endtask

    task automatic test_full_scale();
        for (int c = 0; c < 5; c++) begin
            wr(S_WAVE, c, 0, 8'h80);
            wr(S_VOL, c, 0, 8'd15);
        end
        wr(S_CTRL, 0, 0, 8'h1F);
        wait_tick(); wait_tick();
        n_total++; if (sound_out !== -15'sd9600) begin n_bad++; $display("FAIL full_neg got=%0d want=-9600", sound_out); end
        for (int c = 0; c < 5; c++) wr(S_WAVE, c, 0, 8'h7F);
        wait_tick(); wait_tick();
        n_total++; if (sound_out !== 15'sd9525) begin n_bad++; $display("FAIL full_pos got=%0d want=9525", sound_out); end
    endtask

    task automatic test_share();
        logic [7:0] d; logic v;
        share_mode = 1'b1;
        wr(S_WAVE, 3, 0, 8'h10);
        wr(S_WAVE, 4, 0, 8'hAA);
        wait_tick(); wait_tick();
        n_total++; if (sound_out !== 15'sd6195) begin n_bad++; $display("FAIL share_mix got=%0d want=6195", sound_out); end
        rd(S_WAVE, 4, 0, d, v);
        n_total++; if (v !== 1'b1 || d !== 8'h10) begin n_bad++; $display("FAIL share_read got=%h/%b want=10/1", d, v); end
        share_mode = 1'b0;
        wait_tick(); wait_tick();
        n_total++; if (sound_out !== 15'sd7860) begin n_bad++; $display("FAIL unshare_mix got=%0d want=7860", sound_out); end
        rd(S_WAVE, 4, 0, d, v);
        n_total++; if (d !== 8'h7F) begin n_bad++; $display("FAIL unshare_read got=%h want=7f", d); end
    endtask

    task automatic test_rst_on_freq();
        logic [7:0] d; logic v;
        for (int k = 0; k < 4; k++) wr(S_WAVE, 2, k, 8'(k + 1));
        wr(S_VOL, 2, 0, 8'd1);
        wr(S_CTRL, 0, 0, 8'h84);
        wr(S_FREQ, 2, 0, 8'd9);
        for (int n = 0; n < 4; n++) wait_tick();
        n_total++; if (sound_out !== 15'sd2) begin n_bad++; $display("FAIL rof_before got=%0d want=2", sound_out); end
        wait_tick();
        @(negedge clk); @(negedge clk);
        wr(S_FREQ, 2, 0, 8'd9);
        wait_tick();
        n_total++; if (sound_out !== 15'sd2) begin n_bad++; $display("FAIL rof_same_round got=%0d want=2", sound_out); end
        wait_tick();
        n_total++; if (sound_out !== 15'sd1) begin n_bad++; $display("FAIL rof_ptr_zeroed got=%0d want=1", sound_out); end
        wait_tick();
        n_total++; if (sound_out !== 15'sd2) begin n_bad++; $display("FAIL rof_resumed got=%0d want=2", sound_out); end
        rd(S_VOL, 6, 0, d, v);
        n_total++; if (v !== 1'b1 || d !== 8'hFF) begin n_bad++; $display("FAIL bad_ch_read got=%h/%b want=ff/1", d, v); end
        @(negedge clk);
        n_total++; if (reg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse got=%b want=0", reg_rvalid); end
        n_total++; if (reg_rdata !== 8'hFF) begin n_bad++; $display("FAIL rdata_hold got=%h want=ff", reg_rdata); end
    endtask

    task automatic test_regs();
        logic [7:0] d; logic v;
        wr(S_VOL, 2, 0, 8'hF3);
        rd(S_VOL, 2, 0, d, v);
        n_total++; if (d !== 8'h03) begin n_bad++; $display("FAIL vol_upper got=%h want=03", d); end
        rd(S_CTRL, 0, 0, d, v);
        n_total++; if (d !== 8'h84) begin n_bad++; $display("FAIL ctrl_read got=%h want=84", d); end
        wr(S_FREQ, 0, 1, 8'hFF);
        rd(S_FREQ, 0, 1, d, v);
        n_total++; if (d !== 8'h0F) begin n_bad++; $display("FAIL freq_high got=%h want=0f", d); end
        rd(S_FREQ, 2, 0, d, v);
        n_total++; if (d !== 8'h09) begin n_bad++; $display("FAIL freq_low got=%h want=09", d); end
    endtask

    initial begin
        test_reset_init();
        test_ramp();
        test_reset_mid();
        test_halt();
        test_full_scale();
        test_share();
        test_rst_on_freq();
        test_regs();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
